adder_acc: RTL and testbench

ADDER_ACC -- requirements
Module: adder_acc

---
 rtl/adder_acc.sv | 111 +++++++++++
 tb/tb_adder_acc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_acc.sv
`default_nettype none
// ============================================================================
//  Module   : adder_acc
//  Brief    : Frame accumulator for 9-bit {carry, sum} adder results; emits
//             one total / beat count / overflow flag per frame.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_acc #(
  parameter int TOTAL_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  logic [7:0]         in_sum,
  input  logic               in_carry,
  input  logic               in_last,
  output logic               in_ready,
  output logic               out_valid,
  output logic [TOTAL_W-1:0] out_total,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_ovf,
  input  logic               out_ready
);

  localparam logic [1:0]       ST_IDLE = 2'd0;
  localparam logic [1:0]       ST_ACC  = 2'd1;
  localparam logic [1:0]       ST_HOLD = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic               r_in_ready;
  logic [TOTAL_W-1:0] r_total;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;

  logic               w_accept;
  logic               w_handshake;
  logic [TOTAL_W-1:0] w_beat;
  logic [TOTAL_W:0]   w_sum_ext;
  logic               w_cnt_full;

  assign w_accept    = in_valid & r_in_ready;
  assign w_handshake = out_valid & out_ready;
  assign w_beat      = TOTAL_W'({in_carry, in_sum});
  assign w_sum_ext   = {1'b0, r_total} + {1'b0, w_beat};
  assign w_cnt_full  = (r_count == CNT_MAX);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_ACC: begin
        if (w_accept) begin
          w_next_state = in_last ? ST_HOLD : ST_ACC;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    out_valid = (r_state == ST_HOLD);
    in_ready  = r_in_ready;
    out_total = r_total;
    out_count = r_count;
    out_ovf   = r_ovf;
  end

  // in_ready is registered from the next state so it is low during reset
  // and carries no combinational path from in_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_in_ready <= 1'b0;
      r_total    <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_in_ready <= (w_next_state != ST_HOLD);
      if (w_handshake) begin
        r_total <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_accept) begin
        r_total <= w_sum_ext[TOTAL_W-1:0];
        if (!w_cnt_full) begin
          r_count <= r_count + CNT_W'(1);
        end
        r_ovf <= r_ovf | w_sum_ext[TOTAL_W] | w_cnt_full;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_acc
//  Brief    : Scoreboard bench for adder_acc with a frame-level arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_acc;

  localparam int TOTAL_W = 16;
  localparam int CNT_W   = 8;

  logic               clk       = 1'b0;
  logic               rstn      = 1'b0;
  logic               in_valid  = 1'b0;
  logic [7:0]         in_sum    = 8'd0;
  logic               in_carry  = 1'b0;
  logic               in_last   = 1'b0;
  logic               out_ready = 1'b0;
  logic               in_ready;
  logic               out_valid;
  logic [TOTAL_W-1:0] out_total;
  logic [CNT_W-1:0]   out_count;
  logic               out_ovf;

  adder_acc #(.TOTAL_W(TOTAL_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_sum   (in_sum),
    .in_carry (in_carry),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_total(out_total),
    .out_count(out_count),
    .out_ovf  (out_ovf),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TOTAL_W-1:0] total;
    logic [CNT_W-1:0]   count;
    logic               ovf;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_exp;
  exp_t   mon_prev;
  bit     mon_held = 1'b0;
  int     tests    = 0;
  int     fails    = 0;
  longint f_sum    = 0;
  longint f_n      = 0;
  bit     auto_rdy = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the whole frame is plain integer arithmetic.
  task automatic model_beat(input logic c, input logic [7:0] s, input logic l);
    longint lim;
    longint cmax;
    exp_t   e;
    lim   = longint'(1) << TOTAL_W;
    cmax  = (longint'(1) << CNT_W) - 1;
    f_sum = f_sum + longint'({c, s});
    f_n   = f_n + 1;
    if (l) begin
      e.total = TOTAL_W'(f_sum % lim);
      e.count = CNT_W'((f_n > cmax) ? cmax : f_n);
      e.ovf   = (f_sum >= lim) || (f_n > cmax);
      sb.push_back(e);
      f_sum = 0;
      f_n   = 0;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (auto_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares every presented result against the scoreboard.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (mon_held) begin
        check("hold_total", out_total, mon_prev.total);
        check("hold_count", out_count, mon_prev.count);
        check("hold_ovf", out_ovf, mon_prev.ovf);
      end
      mon_prev.total = out_total;
      mon_prev.count = out_count;
      mon_prev.ovf   = out_ovf;
      if (out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_exp = sb.pop_front();
          check("total", out_total, mon_exp.total);
          check("count", out_count, mon_exp.count);
          check("ovf", out_ovf, mon_exp.ovf);
        end
        mon_held = 1'b0;
      end else begin
        mon_held = 1'b1;
      end
    end else begin
      mon_held = 1'b0;
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_last  = 1'($urandom);
      in_sum   = 8'($urandom);
      in_carry = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_beat(input logic c, input logic [7:0] s, input logic l);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1) begin
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      in_sum   = 8'($urandom);
      in_carry = 1'($urandom);
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        check("in_ready_timeout", 0, 1);
        return;
      end
    end
    in_valid = 1'b1;
    in_carry = c;
    in_sum   = s;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_beat(c, s, l);
    if (l) check("latency_out_valid", out_valid, 1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || out_valid === 1'b1) && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_done", guard < 3000, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset behaviour
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    check("release_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    check("release_in_ready_high", in_ready, 1);

    // Basic frame (expect total 526, count 3)
    out_ready = 1'b1;
    send_beat(1'b0, 8'd10, 1'b0);
    send_beat(1'b1, 8'd255, 1'b0);
    send_beat(1'b0, 8'd5, 1'b1);
    drain();

    // Single beat
    idle_gap(2);
    send_beat(1'b0, 8'd0, 1'b1);
    drain();

    // Total wrap: 129 x 511
    for (int i = 0; i < 129; i++) send_beat(1'b1, 8'd255, (i == 128));
    drain();

    // Count saturation: 300 x 1
    for (int i = 0; i < 300; i++) send_beat(1'b0, 8'd1, (i == 299));
    drain();

    // Backpressure
    out_ready = 1'b0;
    send_beat(1'b0, 8'd100, 1'b0);
    send_beat(1'b1, 8'd3, 1'b0);
    send_beat(1'b0, 8'd77, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_sum   = 8'($urandom);
      in_carry = 1'($urandom);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", out_valid, 0);
    send_beat(1'b0, 8'd9, 1'b1);
    drain();

    // Reset mid-frame
    send_beat(1'b0, 8'd40, 1'b0);
    send_beat(1'b1, 8'd20, 1'b0);
    #3;
    rstn  = 1'b0;
    f_sum = 0;
    f_n   = 0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_back", in_ready, 1);
    send_beat(1'b0, 8'd7, 1'b1);
    drain();

    // Reset while a result is pending
    out_ready = 1'b0;
    send_beat(1'b0, 8'd50, 1'b1);
    #3;
    rstn = 1'b0;
    sb.delete();
    #1;
    check("holdrst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rstn      = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("holdrst_no_result", out_valid, 0);
    end

    // Randomized frames with random output backpressure
    auto_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int b = 0; b < len; b++) begin
        idle_gap($urandom_range(0, 2));
        send_beat(1'($urandom), 8'($urandom), (b == len - 1));
      end
    end
    auto_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
